adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin scheduler that shares one 64-bit `rippleAdder` instance between `N` requesters. Each requester presents two 64-bit operands and holds a request line. The arbiter grants one requester at a time, latches its operands into the adder, and returns a registered 65-bit sum with a one-cycle completion pulse. It also counts completed operations. It sits between client blocks and the single adder datapath, so that only one adder is instantiated.

## Interface
- `N`, 4, number of requesters (2..8); operand buses are packed, requester `i` at bits `[64*i+63 : 64*i]`.
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `REQ`  in  N  per-requester request; held high until its `DONE` pulse.
- `A_IN`  in  64*N  packed A operands.
- `B_IN`  in  64*N  packed B operands.
- `GNT`  out  N  one-hot grant; high from operand latch through the `DONE` cycle.
- `DONE`  out  N  one-hot, one-cycle completion pulse to the granted requester.
- `SUM`  out  65  registered result, `{carry, sum[63:0]}`; holds until the next completion.
- `BUSY`  out  1  high whenever state is not IDLE.
- `OPS_CNT`  out  16  count of completed operations; wraps from 0xFFFF to 0.

## Operation
- **Datapath:** one internal `rippleAdder` is fed from operand registers `op_a` and `op_b`, never directly from `A_IN`/`B_IN`. The result is zero-extended to 65 bits. No overflow flag is produced; bit 64 is the carry.
- **FSM states:** IDLE, EXEC, DONE.
- **IDLE:**
  - If `REQ` is zero, stay in IDLE.
  - Otherwise, select the winner: the first set `REQ` bit scanning `PTR`, `PTR+1`, … `PTR+N-1`, modulo `N`.
  - Latch the winner's `A_IN` and `B_IN` slices into `op_a`/`op_b` and its index into `sel`.
  - Set `GNT` to the winner's one-hot value and go to EXEC.
- **EXEC:**
  - Register the adder output into `SUM`.
  - Set `DONE` to the one-hot value of `sel`.
  - Increment `OPS_CNT` and go to DONE.
- **DONE:**
  - Clear `DONE` and `GNT`.
  - Set `PTR = (sel+1) mod N`.
  - Go to IDLE.
- **Round-robin pointer:** `PTR` changes only on completion. The requester that just completed gets the lowest priority in the next arbitration.
- **REQ deasserted while granted:** the operation still completes, and `DONE` and `SUM` are produced as normal (operands are already latched).
- **Operand changes after latch:** have no effect on the current operation.
- **REQ still high after DONE:** if the requester keeps `REQ` high in the IDLE cycle after DONE, it is treated as a new request and competes under the updated `PTR`.
- **Non-granted requests:** `REQ` from non-granted requesters during EXEC or DONE is ignored until IDLE. No request is lost while it stays asserted.
- **Reset values:**
  - Outputs: `GNT=0`, `DONE=0`, `SUM=0`, `BUSY=0`, `OPS_CNT=0`.
  - Internal: `PTR=0`, state IDLE, `op_a=op_b=0`.
- **Reset during EXEC or DONE:** the operation is aborted. No `DONE` pulse is produced and the count is not incremented.

## Timing
- **Latency:** if `REQ` is sampled at edge k in IDLE, then:
  - `GNT` is valid after edge k.
  - `SUM` and `DONE` are valid after edge k+1.
  - `GNT` and `DONE` drop after edge k+2.
  - State is IDLE again after edge k+2.
- **Throughput:**
  - One operation per 3 cycles with continuous requests.
  - Worst-case wait for a requester held high: 3·(N−1) cycles before its grant.
- **Handshake:** the requester samples `SUM` while its `DONE` is high. A requester wanting no further operation drops `REQ` at the edge where `DONE` falls.
- **Simultaneous events:** multiple `REQ` bits set in the same cycle are resolved solely by the `PTR` scan. Exactly one grant is issued and `GNT` is always one-hot or zero.
- **Adder timing:** the adder is combinational between `op_*` and `SUM`, i.e. one full clock period for the 64-bit ripple path.

## Test plan
- **Reset and idle:**
  - Stimulus: assert `RST` 2 cycles with `REQ=4'b1111`; release it and drop `REQ` the same cycle.
  - Required: all outputs 0 during reset; no `GNT` afterwards; `OPS_CNT=0`.
- **Single request:**
  - Stimulus: requester 2 with A=5, B=8.
  - Required: `GNT=4'b0100` one cycle after the request; `DONE=4'b0100` and `SUM=13` the next cycle; `OPS_CNT=1`; `SUM` holds 13 afterwards.
- **Carry out:**
  - Stimulus: requester 0 with A=64'hFFFF_FFFF_FFFF_FFFF, B=1.
  - Required: `SUM=65'h1_0000_0000_0000_0000`.
- **Round-robin fairness:**
  - Stimulus: `REQ=4'b1111` held continuously, each requester with distinct operands.
  - Required: grant order 0,1,2,3,0; each `DONE` 3 cycles apart; each `SUM` matches its requester's operands.
- **Operand and REQ change mid-operation:**
  - Stimulus: requester 1 with A=100, B=23; at the edge of the grant, change A to 0 and drop `REQ`.
  - Required: `SUM=123` and the `DONE` pulse still occur.
- **Reset mid-operation and counter wrap:**
  - Stimulus: assert `RST` in EXEC.
  - Required: no `DONE`; `OPS_CNT` stays 0.
  - Stimulus: force 65536 completions.
  - Required: `OPS_CNT` reads 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin scheduler sharing one 64-bit ripple adder among N requesters

// ripple_adder: 64-bit carry-ripple adder with carry-out in bit 64
module ripple_adder (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [64:0] o_sum
);
    logic w_c;
    // carry ripples bit by bit from LSB to MSB
    always_comb begin
        w_c = 1'b0;
        o_sum = '0;
        for (int i = 0; i < 64; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_sum[64] = w_c;
    end
endmodule

module adder_arbiter #(
    parameter int N = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    REQ,
    input  logic [64*N-1:0] A_IN,
    input  logic [64*N-1:0] B_IN,
    output logic [N-1:0]    GNT,
    output logic [N-1:0]    DONE,
    output logic [64:0]     SUM,
    output logic            BUSY,
    output logic [15:0]     OPS_CNT
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [IW-1:0] r_ptr, r_sel, w_win;
    logic [63:0]   r_op_a, r_op_b;
    logic [64:0]   w_add, r_sum;
    logic [N-1:0]  r_gnt, r_done;
    logic [15:0]   r_ops_cnt;

    ripple_adder u_ripple_adder (.i_a(r_op_a), .i_b(r_op_b), .o_sum(w_add));

    // first requester at or after the pointer wins; scanning downward lets the nearest overwrite
    always_comb begin
        w_win = r_ptr;
        for (int k = N - 1; k >= 0; k--)
            if (REQ[(int'(r_ptr) + k) % N]) w_win = IW'((int'(r_ptr) + k) % N);
    end

    // next state: IDLE waits for any request, then EXEC and DONE take one cycle each
    always_comb begin
        w_next = (r_state == S_IDLE) ? ((|REQ) ? S_EXEC : S_IDLE) :
                 (r_state == S_EXEC) ? S_DONE : S_IDLE;
    end

    // state register
    always_ff @(posedge CLK) r_state <= RST ? S_IDLE : w_next;

    // operand latch, result capture, grant/done handshake, pointer and counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr     <= '0;
            r_sel     <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_sum     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_ops_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (|REQ) begin
                    r_op_a <= A_IN[64*w_win +: 64];
                    r_op_b <= B_IN[64*w_win +: 64];
                    r_sel  <= w_win;
                    r_gnt  <= N'(1) << w_win;
                end
                S_EXEC: begin
                    r_sum     <= w_add;
                    r_done    <= N'(1) << r_sel;
                    r_ops_cnt <= r_ops_cnt + 16'd1;
                end
                S_DONE: begin
                    r_done <= '0;
                    r_gnt  <= '0;
                    r_ptr  <= (r_sel == IW'(N - 1)) ? '0 : r_sel + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign GNT     = r_gnt;
    assign DONE    = r_done;
    assign SUM     = r_sum;
    assign BUSY    = (r_state != S_IDLE);
    assign OPS_CNT = r_ops_cnt;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random checks of adder_arbiter against a transaction-level model
module tb_adder_arbiter;
    logic         CLK = 1'b0;
    logic         RST;
    logic [3:0]   req;
    logic [255:0] a_in, b_in;
    logic [3:0]   GNT, DONE;
    logic [64:0]  SUM;
    logic         BUSY;
    logic [15:0]  OPS_CNT;

    int          n_checks = 0;
    int          n_fails = 0;
    int          m_ptr = 0;
    logic [15:0] m_cnt = '0;

    adder_arbiter #(.N(4)) dut (
        .CLK(CLK), .RST(RST), .REQ(req), .A_IN(a_in), .B_IN(b_in),
        .GNT(GNT), .DONE(DONE), .SUM(SUM), .BUSY(BUSY), .OPS_CNT(OPS_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_ops;
        for (int i = 0; i < 4; i++) begin
            a_in[64*i +: 64] = {$urandom, $urandom};
            b_in[64*i +: 64] = {$urandom, $urandom};
        end
    endtask

    // one full transaction from IDLE; model picks the winner by scanning from its pointer
    task automatic run_op(input bit mid);
        int          w;
        logic [64:0] e;
        logic [15:0] nc;
        w = 0;
        for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        e = {1'b0, a_in[64*w +: 64]} + {1'b0, b_in[64*w +: 64]};
        nc = m_cnt + 16'd1;
        tick;
        chk("gnt", 65'(GNT), 65'(4'b0001 << w));
        chk("busy_exec", 65'(BUSY), 65'd1);
        chk("done_early", 65'(DONE), 65'd0);
        if (mid) begin
            a_in[64*w +: 64] = '0;
            req[w] = 1'b0;
        end
        tick;
        chk("done", 65'(DONE), 65'(4'b0001 << w));
        chk("gnt_hold", 65'(GNT), 65'(4'b0001 << w));
        chk("sum", SUM, e);
        chk("ops_cnt", 65'(OPS_CNT), 65'(nc));
        tick;
        chk("done_drop", 65'(DONE), 65'd0);
        chk("gnt_drop", 65'(GNT), 65'd0);
        chk("sum_hold", SUM, e);
        chk("busy_idle", 65'(BUSY), 65'd0);
        m_cnt = nc;
        m_ptr = (w + 1) % 4;
    endtask

    initial begin
        RST = 1'b1;
        req = 4'b1111;
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst_gnt", 65'(GNT), 65'd0);
            chk("rst_done", 65'(DONE), 65'd0);
            chk("rst_sum", SUM, 65'd0);
            chk("rst_busy", 65'(BUSY), 65'd0);
            chk("rst_cnt", 65'(OPS_CNT), 65'd0);
        end
        RST = 1'b0;
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("idle_gnt", 65'(GNT), 65'd0);
            chk("idle_busy", 65'(BUSY), 65'd0);
            chk("idle_cnt", 65'(OPS_CNT), 65'd0);
        end

        req = 4'b0001;
        a_in[63:0] = 64'd7;
        b_in[63:0] = 64'd9;
        tick;
        chk("abort_gnt", 65'(GNT), 65'b0001);
        RST = 1'b1;
        tick;
        chk("abort_done", 65'(DONE), 65'd0);
        chk("abort_gnt_clr", 65'(GNT), 65'd0);
        chk("abort_cnt", 65'(OPS_CNT), 65'd0);
        chk("abort_sum", SUM, 65'd0);
        RST = 1'b0;
        req = 4'b0000;
        tick;
        chk("abort_idle", 65'(BUSY), 65'd0);
        chk("abort_no_done", 65'(DONE), 65'd0);
        m_ptr = 0;
        m_cnt = '0;

        rand_ops();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) run_op(1'b0);
        req = 4'b0000;

        a_in[191:128] = 64'd5;
        b_in[191:128] = 64'd8;
        req = 4'b0100;
        run_op(1'b0);
        req = 4'b0000;
        tick;
        chk("single_sum_hold", SUM, 65'd13);
        chk("single_no_gnt", 65'(GNT), 65'd0);

        a_in[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        b_in[63:0] = 64'd1;
        req = 4'b0001;
        run_op(1'b0);
        req = 4'b0000;
        chk("carry_sum", SUM, 65'h1_0000_0000_0000_0000);

        a_in[127:64] = 64'd100;
        b_in[127:64] = 64'd23;
        req = 4'b0010;
        run_op(1'b1);
        chk("mid_sum", SUM, 65'd123);
        req = 4'b0000;

        for (int i = 0; i < 30; i++) begin
            rand_ops();
            req = 4'($urandom_range(1, 15));
            run_op(1'b0);
        end
        req = 4'b0000;
        tick;

        force dut.r_ops_cnt = 16'hFFFE;
        #1;
        release dut.r_ops_cnt;
        m_cnt = 16'hFFFE;
        rand_ops();
        req = 4'b1010;
        run_op(1'b0);
        run_op(1'b0);
        req = 4'b0000;
        chk("wrap_cnt", 65'(OPS_CNT), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
